multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. Steps the shared datapath (PC, IR, register file, ALU, a single unified memory port) through FETCH/DECODE/EXEC/MEM/WB per instruction, driving enables and mux selects. Sits beside the combinational opcode decoder: the decoder supplies datapath control levels; this block decides *when* each enable fires. Also owns the memory request handshake and the illegal-opcode and timeout trap.

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I control constants: opcodes, sequencer state codes,
// pc_src mux codes and trap causes. Also used by the opcode decoder.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_JALR  = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
         default:                           is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB, owns the
// memory handshake and the illegal-opcode / memory-timeout trap.
// Ports: clk, rst (async, active-high), start, opcode, branch_taken,
//   mem_ready -> mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
//   reg_write, busy, trap, trap_cause, state.
// Macro MCTRL_PERF_EN adds cycle_cnt and instret counter outputs.
module multicycle_ctrl
   import rv32i_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       busy,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state
`ifdef MCTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret
`endif
);

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] TO_MAX = '1;

   state_t          st;
   logic [TO_W-1:0] to_cnt;
   logic            to_hit;

   assign state = st;
   assign busy  = (st != S_IDLE) && (st != S_TRAP);

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      reg_write = 1'b0;
      unique case (st)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
         end
         S_EXEC: begin
            if (opcode == OP_BRANCH) begin
               pc_write = 1'b1;
               pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
            end
         end
         S_MEM: begin
            // opcode is stable here, so mem_we cannot glitch mid-request
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OP_STORE);
            pc_write = (opcode == OP_STORE) && mem_ready;
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            if (opcode == OP_JAL)
               pc_src = PC_IMM;
            else if (opcode == OP_JALR)
               pc_src = PC_JALR;
         end
         default: ;
      endcase
   end

   // mem_ready in the same cycle always beats the timeout
   assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LIM)
                   && mem_req && !mem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= S_IDLE;
         to_cnt     <= '0;
         trap       <= 1'b0;
         trap_cause <= CAUSE_NONE;
      end else begin
         if (mem_req && !mem_ready && !to_hit) begin
            if (to_cnt != TO_MAX)
               to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end

         unique case (st)
            S_IDLE:
               if (start) st <= S_FETCH;
            S_FETCH:
               if (mem_ready) begin
                  st <= S_DECODE;
               end else if (to_hit) begin
                  st         <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_TIMEOUT;
               end
            S_DECODE:
               if (is_legal(opcode)) begin
                  st <= S_EXEC;
               end else begin
                  st         <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_ILLEGAL;
               end
            S_EXEC:
               if (opcode == OP_LOAD || opcode == OP_STORE)
                  st <= S_MEM;
               else if (opcode == OP_BRANCH)
                  st <= S_FETCH;
               else
                  st <= S_WB;
            S_MEM:
               if (mem_ready) begin
                  st <= (opcode == OP_STORE) ? S_FETCH : S_WB;
               end else if (to_hit) begin
                  st         <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_TIMEOUT;
               end
            S_WB:
               st <= S_FETCH;
            S_TRAP:
               st <= S_TRAP;
            default:
               st <= S_IDLE;
         endcase
      end
   end

`ifdef MCTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         instret   <= '0;
      end else begin
         if (busy)     cycle_cnt <= cycle_cnt + 32'd1;
         if (pc_write) instret   <= instret + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams checked cycle by cycle against a per-instruction expected trace.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
   logic       busy, trap;
   logic [1:0] pc_src, trap_cause;
   logic [2:0] state;
`ifdef MCTRL_PERF_EN
   logic [31:0] cycle_cnt, instret;
`endif

   multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .busy(busy), .trap(trap),
      .trap_cause(trap_cause), .state(state)
`ifdef MCTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic        exp_trap;
   logic [1:0]  exp_cause;
   int unsigned exp_cyc, exp_ret;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic legal(input logic [6:0] op);
      case (op)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   endfunction

   // one clock cycle: apply mem_ready, compare every output, advance
   task automatic cyc(input string ph, input logic [2:0] es,
                      input logic mr, input logic req, input logic we,
                      input logic asel, input logic irw, input logic pcw,
                      input logic [1:0] pcs, input logic rw);
      logic eb;
      mem_ready = mr;
      #1;
      eb = (es != 3'd0) && (es != 3'd7);
`ifdef MCTRL_PERF_EN
      chk({ph, ".cycle_cnt"}, cycle_cnt, exp_cyc);
      chk({ph, ".instret"}, instret, exp_ret);
`endif
      chk({ph, ".state"}, 32'(state), 32'(es));
      chk({ph, ".mem_req"}, 32'(mem_req), 32'(req));
      chk({ph, ".mem_we"}, 32'(mem_we), 32'(we));
      chk({ph, ".addr_sel"}, 32'(addr_sel), 32'(asel));
      chk({ph, ".ir_write"}, 32'(ir_write), 32'(irw));
      chk({ph, ".pc_write"}, 32'(pc_write), 32'(pcw));
      chk({ph, ".reg_write"}, 32'(reg_write), 32'(rw));
      if (pcw || es == 3'd0)
         chk({ph, ".pc_src"}, 32'(pc_src), 32'(pcs));
      chk({ph, ".busy"}, 32'(busy), 32'(eb));
      chk({ph, ".trap"}, 32'(trap), 32'(exp_trap));
      chk({ph, ".trap_cause"}, 32'(trap_cause), 32'(exp_cause));
      if (eb) exp_cyc++;
      if (pcw) exp_ret++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_start();
      start = 1'b1;
      cyc("idle", 3'd0, 1'b0, 0, 0, 0, 0, 0, 2'd0, 0);
      start = 1'b0;
   endtask

   task automatic trap_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'($urandom);
         cyc("trap", 3'd7, 1'($urandom), 0, 0, 0, 0, 0, 2'd0, 0);
      end
      start = 1'b0;
   endtask

   // asynchronous reset out of TRAP, then restart fetching
   task automatic recover();
      #3 rst = 1'b1;
      #1;
      chk("arst.state", 32'(state), 0);
      chk("arst.trap", 32'(trap), 0);
      chk("arst.cause", 32'(trap_cause), 0);
      chk("arst.busy", 32'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_trap = 1'b0; exp_cause = 2'd0;
      exp_cyc = 0; exp_ret = 0;
      idle_start();
   endtask

   // waits of 5 or more exceed MEM_TIMEOUT=4 and must trap
   task automatic run_instr(input logic [6:0] op, input int fw,
                            input int mw, input logic bt,
                            output logic trapped);
      logic ld, st, rdy;
      logic [1:0] wpcs;
      trapped = 1'b0;
      ld = (op == 7'b0000011);
      st = (op == 7'b0100011);
      opcode = 7'($urandom);
      for (int i = 0; i <= fw && i <= 4; i++) begin
         rdy = (i == fw);
         cyc("fetch", 3'd1, rdy, 1, 0, 0, rdy, 0, 2'd0, 0);
      end
      if (fw > 4) begin
         exp_trap = 1'b1; exp_cause = 2'd2;
         trap_cycles(3);
         trapped = 1'b1;
         return;
      end
      opcode = op;
      cyc("decode", 3'd2, 1'($urandom), 0, 0, 0, 0, 0, 2'd0, 0);
      if (!legal(op)) begin
         exp_trap = 1'b1; exp_cause = 2'd1;
         trap_cycles(3);
         trapped = 1'b1;
         return;
      end
      branch_taken = bt;
      if (op == 7'b1100011) begin
         cyc("exec.br", 3'd3, 1'($urandom), 0, 0, 0, 0, 1,
             bt ? 2'd1 : 2'd0, 0);
         return;
      end
      cyc("exec", 3'd3, 1'($urandom), 0, 0, 0, 0, 0, 2'd0, 0);
      if (ld || st) begin
         for (int i = 0; i <= mw && i <= 4; i++) begin
            rdy = (i == mw);
            cyc("mem", 3'd4, rdy, 1, st, 1, 0, st && rdy, 2'd0, 0);
         end
         if (mw > 4) begin
            exp_trap = 1'b1; exp_cause = 2'd2;
            trap_cycles(3);
            trapped = 1'b1;
            return;
         end
         if (st) return;
      end
      wpcs = (op == 7'b1101111) ? 2'd1 : (op == 7'b1100111) ? 2'd2 : 2'd0;
      cyc("wb", 3'd5, 1'($urandom), 0, 0, 0, 0, 1, wpcs, 1);
   endtask

   logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                           7'b0100011, 7'b1100011, 7'b1101111,
                           7'b1100111, 7'b0110111, 7'b0010111};

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic tr;
      logic [6:0] op;
      int fw, mw;
      rst = 1'b1; start = 1'b0; opcode = '0;
      branch_taken = 1'b0; mem_ready = 1'b0;
      exp_trap = 1'b0; exp_cause = 2'd0;
      exp_cyc = 0; exp_ret = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.state", 32'(state), 0);
      chk("reset.trap", 32'(trap), 0);
      chk("reset.busy", 32'(busy), 0);
      rst = 1'b0;
      cyc("idle", 3'd0, 1'b1, 0, 0, 0, 0, 0, 2'd0, 0);
      idle_start();

      run_instr(7'b0110011, 0, 0, 0, tr);
      run_instr(7'b0110011, 0, 0, 0, tr);
      run_instr(7'b0000011, 0, 3, 0, tr);
      run_instr(7'b1100011, 0, 0, 1, tr);
      run_instr(7'b1100011, 0, 0, 0, tr);
      run_instr(7'b1100111, 1, 0, 0, tr);
      run_instr(7'b1101111, 0, 0, 0, tr);
      run_instr(7'b0100011, 2, 4, 0, tr);
      run_instr(7'b0000011, 4, 4, 0, tr);
      run_instr(7'b1111111, 0, 0, 0, tr);
      recover();
      run_instr(7'b0110011, 5, 0, 0, tr);
      recover();
      run_instr(7'b0100011, 0, 5, 0, tr);
      recover();

      for (int n = 0; n < 300; n++) begin
         op = ($urandom_range(0, 9) == 0) ? 7'($urandom)
                                          : ops[$urandom_range(0, 8)];
         fw = ($urandom_range(0, 24) == 0) ? 5 : $urandom_range(0, 4);
         mw = ($urandom_range(0, 24) == 0) ? 5 : $urandom_range(0, 4);
         run_instr(op, fw, mw, 1'($urandom), tr);
         if (tr) recover();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
